// File: rtl/rr_arbiter8_seg_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8_seg_if
//  Description : Request/grant bundle for the 8-way round-robin arbiter with
//                7-segment grantee display.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter8_seg_if;
   logic       enable;     // arbitration enable
   logic [7:0] req;        // request lines, bit i is requester i
   logic       done;       // current grantee finished (looked at only while granted)
   logic [7:0] gnt;        // one-hot grant vector
   logic [2:0] gnt_idx;    // binary index of the grantee
   logic       gnt_valid;  // a grant is being held
   logic       timeout;    // one-cycle pulse after a hold-limit release
   logic [6:0] hex0;       // active-low segments, bit0=a .. bit6=g

   // Requester side: drives requests, observes grants
   modport master (
      output enable, req, done,
      input  gnt, gnt_idx, gnt_valid, timeout, hex0
   );

   // Arbiter side
   modport slave (
      input  enable, req, done,
      output gnt, gnt_idx, gnt_valid, timeout, hex0
   );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter8_seg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8_seg
//  Description : 8-requester round-robin arbiter with a bounded hold time,
//                a timeout pulse on forced release and a 7-segment display
//                of the current grantee index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8_seg #(
   parameter int unsigned MAX_HOLD = 255   // cycles a grant may be held (1..65535)
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   rr_arbiter8_seg_if.slave     arb
);

   // Counter value at which the grant has been held MAX_HOLD cycles
   localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
   localparam logic [6:0]  SEG_BLANK = 7'h7F;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // First set request bit scanning p, p+1, ..., p+7 (mod 8).
   // Result is {found, index}.
   // ---------------------------------------------------------------------
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic       found;
      logic [2:0] idx;
      logic [2:0] cand;
      found = 1'b0;
      idx   = p;
      for (int k = 0; k < 8; k++) begin
         cand = p + 3'(k);
         if (!found && r[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   // Active-low segment pattern for a single digit 0..7
   function automatic logic [6:0] seg7(input logic [2:0] d);
      logic [6:0] s;
      case (d)
         3'd0:    s = 7'h40;
         3'd1:    s = 7'h79;
         3'd2:    s = 7'h24;
         3'd3:    s = 7'h30;
         3'd4:    s = 7'h19;
         3'd5:    s = 7'h12;
         3'd6:    s = 7'h02;
         default: s = 7'h78;
      endcase
      return s;
   endfunction

   state_t      state_q,     state_d;
   logic [2:0]  ptr_q,       ptr_d;
   logic [7:0]  gnt_q,       gnt_d;
   logic [2:0]  gnt_idx_q,   gnt_idx_d;
   logic        gnt_valid_q, gnt_valid_d;
   logic        timeout_q,   timeout_d;
   logic [15:0] hold_cnt_q,  hold_cnt_d;
   logic [6:0]  hex0_q,      hex0_d;

   logic [3:0]  pick;
   logic        win_found;
   logic [2:0]  win_idx;
   logic        hold_last;
   logic        owner_req;
   logic        normal_release;

   assign pick      = rr_pick(arb.req, ptr_q);
   assign win_found = pick[3];
   assign win_idx   = pick[2:0];
   assign hold_last = (hold_cnt_q == HOLD_LAST);
   assign owner_req = arb.req[gnt_idx_q];
   // done, a dropped request or the hold limit all end the grant the same way
   assign normal_release = arb.done || !owner_req || hold_last;

   // Next-state and next-output computation for the IDLE/GRANT machine
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;

      case (state_q)
         IDLE: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
            if (arb.enable && win_found) begin
               state_d     = GRANT;
               gnt_d       = 8'(1) << win_idx;
               gnt_idx_d   = win_idx;
               gnt_valid_d = 1'b1;
            end
         end

         GRANT: begin
            if (!arb.enable) begin
               // Disable aborts the grant without rotating priority
               state_d     = IDLE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
            end else if (normal_release) begin
               state_d     = IDLE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
               ptr_d       = gnt_idx_q + 3'd1;
               // Pulse only when the hold limit alone ended the grant
               timeout_d   = hold_last && !arb.done && owner_req;
            end else begin
               hold_cnt_d  = hold_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
         end
      endcase
   end

   // Display follows the next grant state so it is registered alongside it
   always_comb begin
      hex0_d = gnt_valid_d ? seg7(gnt_idx_d) : SEG_BLANK;
   end

   // State and registered outputs; reset clears everything asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
         hex0_q      <= SEG_BLANK;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         hex0_q      <= hex0_d;
      end
   end

   assign arb.gnt       = gnt_q;
   assign arb.gnt_idx   = gnt_idx_q;
   assign arb.gnt_valid = gnt_valid_q;
   assign arb.timeout   = timeout_q;
   assign arb.hex0      = hex0_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8_seg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8_seg
//  Description : Self-checking bench for rr_arbiter8_seg (MAX_HOLD=4):
//                vector table, hand-written corner sequences and a randomized
//                run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8_seg;

   localparam int HOLD = 4;

   logic clk;
   logic rst_n;

   rr_arbiter8_seg_if bus ();

   rr_arbiter8_seg #(.MAX_HOLD(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .arb   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       to;
      logic [6:0] hex;
   } vec_t;

   vec_t       vecs[$];
   logic [6:0] seg_tab [8];
   int         n_cmp;
   int         n_err;

   // Behavioural model: who holds the grant, for how many cycles, where
   // the round-robin search starts, and whether a timeout pulse is showing.
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_age;
   bit m_to;

   task automatic add(input logic en, input logic [7:0] rq, input logic dn,
                      input logic [7:0] g, input logic [2:0] ix, input logic v,
                      input logic t, input logic [6:0] h);
      vec_t r;
      r.en = en; r.req = rq; r.done = dn;
      r.gnt = g; r.idx = ix; r.valid = v; r.to = t; r.hex = h;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] ix,
                          input logic v, input logic t, input logic [6:0] h);
      chk({tag, ".gnt"},       16'(bus.gnt),       16'(g));
      chk({tag, ".gnt_idx"},   16'(bus.gnt_idx),   16'(ix));
      chk({tag, ".gnt_valid"}, 16'(bus.gnt_valid), 16'(v));
      chk({tag, ".timeout"},   16'(bus.timeout),   16'(t));
      chk({tag, ".hex0"},      16'(bus.hex0),      16'(h));
   endtask

   // Apply inputs away from the edge, clock once, settle
   task automatic step(input logic en, input logic [7:0] rq, input logic dn);
      bus.enable = en;
      bus.req    = rq;
      bus.done   = dn;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_to = 0;
   endtask

   // One clock edge of the arbitration rules
   task automatic model_step(input logic en, input logic [7:0] rq, input logic dn);
      bit nto;
      bit picked;
      nto = 0;
      if (!m_busy) begin
         picked = 0;
         if (en) begin
            for (int i = 0; i < 8; i++) begin
               int c;
               c = (m_ptr + i) % 8;
               if (!picked && rq[c]) begin
                  picked  = 1;
                  m_owner = c;
               end
            end
         end
         if (picked) begin
            m_busy = 1;
            m_age  = 1;
         end
      end else begin
         if (!en) begin
            m_busy = 0;
         end else if (dn || !rq[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 8;
         end else if (m_age == HOLD) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 8;
            nto    = 1;
         end else begin
            m_age = m_age + 1;
         end
      end
      m_to = nto;
   endtask

   task automatic model_check(input string tag);
      logic [7:0] g;
      logic [6:0] h;
      g = m_busy ? (8'(1) << m_owner) : 8'h00;
      h = m_busy ? seg_tab[m_owner] : 7'h7F;
      chk_all(tag, g, 3'(m_owner), m_busy, m_to, h);
   endtask

   initial begin
      logic [7:0] rq;
      logic       en;
      logic       dn;

      n_cmp = 0;
      n_err = 0;
      seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
      seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;

      // ---- vector table (ptr evolution noted per group) ----
      // req=0x81: grant 0, release on done (ptr 1), then grant 7 (ptr 0)
      add(1, 8'h81, 0, 8'h01, 3'd0, 1, 0, 7'h40);
      add(1, 8'h81, 1, 8'h00, 3'd0, 0, 0, 7'h7F);
      add(1, 8'h81, 0, 8'h80, 3'd7, 1, 0, 7'h78);
      add(1, 8'h81, 1, 8'h00, 3'd7, 0, 0, 7'h7F);
      // req=0xFF, done held high: 0,1,..,7,0 with an idle cycle between (ptr 1)
      for (int k = 0; k < 9; k++) begin
         add(1, 8'hFF, 1, 8'(1) << (k % 8), 3'(k % 8), 1, 0, seg_tab[k % 8]);
         add(1, 8'hFF, 1, 8'h00,            3'(k % 8), 0, 0, 7'h7F);
      end
      // req=0x04 held: four grant cycles, then release with timeout (ptr 3)
      for (int k = 0; k < HOLD; k++) add(1, 8'h04, 0, 8'h04, 3'd2, 1, 0, 7'h24);
      add(1, 8'h04, 0, 8'h00, 3'd2, 0, 1, 7'h7F);
      add(1, 8'h00, 0, 8'h00, 3'd2, 0, 0, 7'h7F);
      // grant 3, enable drop aborts; 0x09 reissues 3, so ptr stayed at 3
      add(1, 8'h09, 0, 8'h08, 3'd3, 1, 0, 7'h30);
      add(0, 8'h09, 0, 8'h00, 3'd3, 0, 0, 7'h7F);
      add(1, 8'h09, 0, 8'h08, 3'd3, 1, 0, 7'h30);
      add(1, 8'h09, 1, 8'h00, 3'd3, 0, 0, 7'h7F);  // ptr 4
      add(1, 8'h09, 0, 8'h01, 3'd0, 1, 0, 7'h40);
      add(1, 8'h09, 1, 8'h00, 3'd0, 0, 0, 7'h7F);  // ptr 1
      // grant 2, req[2] drops: release, no timeout, ptr 3 -> 0x0D picks 3
      add(1, 8'h04, 0, 8'h04, 3'd2, 1, 0, 7'h24);
      add(1, 8'h09, 0, 8'h00, 3'd2, 0, 0, 7'h7F);
      add(1, 8'h0D, 0, 8'h08, 3'd3, 1, 0, 7'h30);
      add(1, 8'h00, 0, 8'h00, 3'd3, 0, 0, 7'h7F);  // ptr 4
      // enable low in IDLE blocks grants
      add(0, 8'hFF, 0, 8'h00, 3'd3, 0, 0, 7'h7F);
      add(0, 8'hFF, 0, 8'h00, 3'd3, 0, 0, 7'h7F);
      add(1, 8'hFF, 1, 8'h10, 3'd4, 1, 0, 7'h19);
      add(1, 8'hFF, 1, 8'h00, 3'd4, 0, 0, 7'h7F);  // ptr 5

      // ---- reset state ----
      bus.enable = 0; bus.req = '0; bus.done = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 8'h00, 3'd0, 0, 0, 7'h7F);
      rst_n = 1;

      // ---- table ----
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].req, vecs[i].done);
         chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid,
                 vecs[i].to, vecs[i].hex);
      end

      // ---- async reset in the middle of a grant ----
      step(1, 8'h20, 0);
      chk_all("pre_rst", 8'h20, 3'd5, 1, 0, 7'h12);
      #1 rst_n = 0;
      #1 chk_all("async_rst", 8'h00, 3'd0, 0, 0, 7'h7F);
      #1 rst_n = 1;
      step(1, 8'h21, 0);
      chk_all("post_rst", 8'h01, 3'd0, 1, 0, 7'h40);
      step(1, 8'h21, 1);
      chk_all("post_rst_rel", 8'h00, 3'd0, 0, 0, 7'h7F);  // ptr 1

      // ---- done coinciding with the hold limit: no timeout pulse ----
      step(1, 8'h40, 0);
      for (int k = 1; k < HOLD; k++) step(1, 8'h40, 0);
      chk_all("hold_full", 8'h40, 3'd6, 1, 0, 7'h02);
      step(1, 8'h40, 1);
      chk_all("limit_and_done", 8'h00, 3'd6, 0, 0, 7'h7F);
      step(1, 8'h00, 0);
      chk_all("limit_and_done_after", 8'h00, 3'd6, 0, 0, 7'h7F);

      // ---- randomized run against the model ----
      #1 rst_n = 0;
      #1 rst_n = 1;
      model_reset();
      rq = '0;
      for (int n = 0; n < 3000; n++) begin
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 3) == 0) rq = 8'($urandom) & 8'($urandom);
         dn = ($urandom_range(0, 4) == 0);
         step(en, rq, dn);
         model_step(en, rq, dn);
         model_check($sformatf("rand%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
